// File: rtl/pass_entry_pkg.sv
// Shared types and width helpers for the keypad pass-entry front end.
package pass_entry_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam int unsigned DEF_PASS_W      = 5;
    localparam int unsigned DEF_TIMEOUT_CYC = 1000;
    localparam int unsigned DEF_PRESENT_CYC = 16;
    localparam int unsigned DEF_MAX_FAIL    = 3;
    localparam int unsigned DEF_LOCK_CYC    = 4000;
    localparam int unsigned DIGIT_W         = 3;

    // Timers are loaded with (cycles - 1), so the largest duration minus one must fit.
    function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

    function automatic int unsigned fail_width(input int unsigned max_fail);
        return (max_fail > 1) ? $clog2(max_fail + 1) : 1;
    endfunction

endpackage

// File: rtl/pass_entry_unit_cycle_timer.sv
// Down-counter shared by all timed states; expired is high once the count reaches zero.
module cycle_timer #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/pass_entry_unit.sv
// Keypad front end: collects a serial code, presents it for a fixed window,
// times out stalled entries and locks the keypad after repeated failures.
module pass_entry_unit
    import pass_entry_pkg::*;
#(
    parameter int unsigned PASS_W      = DEF_PASS_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned PRESENT_CYC = DEF_PRESENT_CYC,
    parameter int unsigned MAX_FAIL    = DEF_MAX_FAIL,
    parameter int unsigned LOCK_CYC    = DEF_LOCK_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic              key_bit,
    input  logic              key_clear,
    input  logic              key_enter,
    input  logic              accepted,
    output logic [PASS_W-1:0] pass,
    output logic              pass_valid,
    output logic [DIGIT_W-1:0] digit_cnt,
    output logic              locked,
    output logic              timeout,
    output logic              short_err
);

    localparam int unsigned TMR_W  = tmr_width(TIMEOUT_CYC, PRESENT_CYC, LOCK_CYC);
    localparam int unsigned FAIL_W = fail_width(MAX_FAIL);

    state_t              state;
    logic [PASS_W-1:0]   shreg;
    logic [FAIL_W-1:0]   fail_cnt;
    logic                hit;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_value;
    logic                tmr_expired;

    logic [FAIL_W-1:0]   fail_inc;
    logic                fail_lock;
    logic                code_full;
    logic                hit_any;
    logic                start;

    assign fail_inc  = (fail_cnt == FAIL_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + FAIL_W'(1);
    assign fail_lock = (fail_inc == FAIL_W'(MAX_FAIL));
    assign code_full = (digit_cnt == DIGIT_W'(PASS_W));
    assign hit_any   = hit | accepted;
    assign start     = key_valid & ~key_clear & ~key_enter;

    // Timer reload follows the state being entered (or the key event that restarts it).
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(TIMEOUT_CYC - 1);
                end
            end
            COLLECT: begin
                if (key_clear || key_enter || key_valid) begin
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(TIMEOUT_CYC - 1);
                    if (!key_clear && key_enter) begin
                        if (code_full) begin
                            tmr_value = TMR_W'(PRESENT_CYC - 1);
                        end else begin
                            tmr_value = TMR_W'(LOCK_CYC - 1);
                        end
                    end
                end
            end
            PRESENT: begin
                if (tmr_expired && !hit_any && fail_lock) begin
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(LOCK_CYC - 1);
                end
            end
            default: begin
            end
        endcase
    end

    cycle_timer #(.W(TMR_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            digit_cnt  <= '0;
            fail_cnt   <= '0;
            hit        <= 1'b0;
            pass       <= '0;
            pass_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            short_err  <= 1'b0;
        end else begin
            timeout   <= 1'b0;
            short_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg     <= {{(PASS_W-1){1'b0}}, key_bit};
                        digit_cnt <= DIGIT_W'(1);
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (key_clear) begin
                        shreg     <= '0;
                        digit_cnt <= '0;
                        state     <= IDLE;
                    end else if (key_enter) begin
                        if (code_full) begin
                            pass       <= shreg;
                            pass_valid <= 1'b1;
                            hit        <= 1'b0;
                            state      <= PRESENT;
                        end else begin
                            short_err <= 1'b1;
                            fail_cnt  <= fail_inc;
                            shreg     <= '0;
                            digit_cnt <= '0;
                            locked    <= fail_lock;
                            state     <= fail_lock ? LOCKOUT : IDLE;
                        end
                    end else if (key_valid) begin
                        if (!code_full) begin
                            shreg     <= {shreg[PASS_W-2:0], key_bit};
                            digit_cnt <= digit_cnt + DIGIT_W'(1);
                        end
                    end else if (tmr_expired) begin
                        timeout   <= 1'b1;
                        shreg     <= '0;
                        digit_cnt <= '0;
                        state     <= IDLE;
                    end
                end
                PRESENT: begin
                    hit <= hit_any;
                    if (tmr_expired) begin
                        pass       <= '0;
                        pass_valid <= 1'b0;
                        shreg      <= '0;
                        digit_cnt  <= '0;
                        hit        <= 1'b0;
                        if (hit_any) begin
                            fail_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            fail_cnt <= fail_inc;
                            locked   <= fail_lock;
                            state    <= fail_lock ? LOCKOUT : IDLE;
                        end
                    end
                end
                LOCKOUT: begin
                    if (tmr_expired) begin
                        locked   <= 1'b0;
                        fail_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
